// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 3-stage F/D/E core: load-use bubbles, redirect
// squashes, halt requests, data-memory wait/timeout and a stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirectE,
    input  logic             mem_accessE,
    input  logic             mem_writeE,
    input  logic             reg_writeE,
    input  logic [4:0]       rdE,
    input  logic [4:0]       adr1D,
    input  logic [4:0]       adr2D,
    input  logic             use_rs1D,
    input  logic             use_rs2D,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             dmem_req,
    output logic [1:0]       state,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam int              WC_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
    localparam logic [WC_W-1:0] WC_ZERO = WC_W'(0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [WC_W-1:0]  wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_e_s;
    logic             hazard_s;

    assign load_e_s = mem_accessE & ~mem_writeE & reg_writeE & (rdE != 5'd0);
    assign hazard_s = load_e_s & ((use_rs1D & (adr1D == rdE)) | (use_rs2D & (adr2D == rdE)));

    assign state           = state_q;
    assign mem_timeout_err = err_q;
    assign stall_cnt       = cnt_q;

    // Output decode and next-state selection from registered state plus live inputs
    always_comb begin
        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        dmem_req = 1'b0;
        state_d  = state_q;
        wait_d   = wait_q;
        err_d    = err_q;
        if (!rst_n) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else begin
            case (state_q)
                ST_RUN, ST_WAIT: begin
                    dmem_req = (state_q == ST_WAIT) | mem_accessE;
                    if (dmem_req && !dmem_ready) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        stallE = 1'b1;
                        if (state_q == ST_RUN) begin
                            state_d = ST_WAIT;
                            wait_d  = WC_ONE;
                        end else if (wait_q == WC_MAX) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else begin
                            wait_d = wait_q + WC_ONE;
                        end
                    end else begin
                        // Access (if any) is done; redirect beats the load-use bubble
                        state_d = ST_RUN;
                        wait_d  = WC_ZERO;
                        if (redirectE) begin
                            flushD = 1'b1;
                            flushE = 1'b1;
                        end else if (hazard_s) begin
                            stallF = 1'b1;
                            stallD = 1'b1;
                            flushE = 1'b1;
                        end else if (halt_req && (state_q == ST_RUN)) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_HALT: begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    if (!halt_req) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
                ST_ERR: begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    err_d  = 1'b1;
                end
                default: begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        if (stallF && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            wait_q  <= WC_ZERO;
            err_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl, checked every cycle
// against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 255;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0, redirectE = 1'b0, mem_accessE = 1'b0, mem_writeE = 1'b0;
    logic reg_writeE = 1'b0, use_rs1D = 1'b0, use_rs2D = 1'b0;
    logic dmem_ready = 1'b0, halt_req = 1'b0;
    logic [4:0] rdE = 5'd0, adr1D = 5'd0, adr2D = 5'd0;
    logic stallF, stallD, stallE, flushD, flushE, dmem_req, mem_timeout_err;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: mode 0 run, 1 waiting on memory, 2 halted, 3 error
    int m_mode = 0, m_wait = 0, m_err = 0, m_cnt = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .redirectE(redirectE), .mem_accessE(mem_accessE),
        .mem_writeE(mem_writeE), .reg_writeE(reg_writeE), .rdE(rdE), .adr1D(adr1D),
        .adr2D(adr2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D), .dmem_ready(dmem_ready),
        .halt_req(halt_req), .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .dmem_req(dmem_req), .state(state),
        .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs are already applied; predict, compare, advance model
    task automatic cyc();
        int e_sf, e_sd, e_se, e_fd, e_fe, e_req, n_mode, n_wait, n_err, n_cnt;
        bit is_load, uses_rd, busy;
        #1;
        e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0; e_req = 0;
        n_mode = m_mode; n_wait = m_wait; n_err = m_err; n_cnt = m_cnt;
        is_load = mem_accessE && !mem_writeE && reg_writeE && (rdE != 0);
        uses_rd = (use_rs1D && adr1D == rdE) || (use_rs2D && adr2D == rdE);
        if (!rst_n) begin
            e_fd = 1; e_fe = 1;
            n_mode = 0; n_wait = 0; n_err = 0; n_cnt = 0;
        end else begin
            if (m_mode >= 2) begin
                e_sf = 1; e_sd = 1; e_se = 1;
                if (m_mode == 2 && !halt_req) n_mode = 0;
            end else begin
                e_req = (m_mode == 1 || mem_accessE) ? 1 : 0;
                busy  = (e_req == 1) && !dmem_ready;
                if (busy) begin
                    e_sf = 1; e_sd = 1; e_se = 1;
                    if (m_mode == 0) begin n_mode = 1; n_wait = 1; end
                    else if (m_wait == TIMEOUT) begin n_mode = 3; n_err = 1; end
                    else n_wait = m_wait + 1;
                end else begin
                    n_mode = 0; n_wait = 0;
                    if (redirectE) begin e_fd = 1; e_fe = 1; end
                    else if (is_load && uses_rd) begin e_sf = 1; e_sd = 1; e_fe = 1; end
                    else if (halt_req && m_mode == 0) n_mode = 2;
                end
            end
            if (e_sf == 1) n_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        end
        check("stallF", int'(stallF), e_sf);
        check("stallD", int'(stallD), e_sd);
        check("stallE", int'(stallE), e_se);
        check("flushD", int'(flushD), e_fd);
        check("flushE", int'(flushE), e_fe);
        check("dmem_req", int'(dmem_req), e_req);
        check("state", int'(state), m_mode);
        check("timeout_err", int'(mem_timeout_err), m_err);
        check("stall_cnt", int'(stall_cnt), m_cnt);
        @(posedge clk);
        m_mode = n_mode; m_wait = n_wait; m_err = n_err; m_cnt = n_cnt;
        @(negedge clk);
    endtask

    task automatic clear_e();
        redirectE = 1'b0; mem_accessE = 1'b0; mem_writeE = 1'b0; reg_writeE = 1'b0;
        rdE = 5'd0; adr1D = 5'd0; adr2D = 5'd0; use_rs1D = 1'b0; use_rs2D = 1'b0;
        dmem_ready = 1'b0; halt_req = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b0; clear_e();
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Load-use on rs1: single bubble
        mem_accessE = 1'b1; reg_writeE = 1'b1; rdE = 5'd5; adr1D = 5'd5; use_rs1D = 1'b1;
        dmem_ready = 1'b1;
        cyc();
        clear_e(); cyc();
        check("loaduse_cnt", int'(stall_cnt), 1);

        // Load into x0 never stalls
        mem_accessE = 1'b1; reg_writeE = 1'b1; rdE = 5'd0; adr1D = 5'd0; use_rs1D = 1'b1;
        dmem_ready = 1'b1;
        cyc();
        check("x0_cnt", int'(stall_cnt), 1);

        // Redirect coinciding with a hazard on rs2
        mem_accessE = 1'b1; reg_writeE = 1'b1; rdE = 5'd7; adr2D = 5'd7; use_rs2D = 1'b1;
        use_rs1D = 1'b0; redirectE = 1'b1; dmem_ready = 1'b1;
        cyc();
        check("redir_cnt", int'(stall_cnt), 1);
        clear_e(); cyc();

        // Store with three not-ready cycles
        mem_accessE = 1'b1; mem_writeE = 1'b1;
        repeat (3) cyc();
        check("wait_state", int'(state), 1);
        dmem_ready = 1'b1; cyc();
        check("wait_cnt", int'(stall_cnt), 4);
        clear_e(); cyc();
        check("wait_done", int'(state), 0);

        // Load plus redirect, ready after two cycles
        mem_accessE = 1'b1; reg_writeE = 1'b1; rdE = 5'd9; redirectE = 1'b1;
        repeat (2) cyc();
        dmem_ready = 1'b1; cyc();
        clear_e(); cyc();

        // Halt and counter saturation
        halt_req = 1'b1; cyc();
        check("halt_state", int'(state), 2);
        repeat (20) cyc();
        check("sat_cnt", int'(stall_cnt), CMAX);
        halt_req = 1'b0; cyc();
        check("halt_exit", int'(state), 0);

        // Memory timeout, then reset out of ERR
        mem_accessE = 1'b1; mem_writeE = 1'b1;
        repeat (TIMEOUT + 10) cyc();
        check("err_state", int'(state), 3);
        check("err_flag", int'(mem_timeout_err), 1);
        rst_n = 1'b0; cyc();
        rst_n = 1'b1; clear_e();
        check("rst_state", int'(state), 0);
        check("rst_err", int'(mem_timeout_err), 0);
        check("rst_cnt", int'(stall_cnt), 0);
        cyc();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_n       = ($urandom_range(0, 63) != 0);
            redirectE   = ($urandom_range(0, 5) == 0);
            mem_accessE = $urandom_range(0, 1) == 1;
            mem_writeE  = ($urandom_range(0, 3) == 0);
            reg_writeE  = $urandom_range(0, 1) == 1;
            rdE         = 5'($urandom_range(0, 3));
            adr1D       = 5'($urandom_range(0, 3));
            adr2D       = 5'($urandom_range(0, 3));
            use_rs1D    = $urandom_range(0, 1) == 1;
            use_rs2D    = $urandom_range(0, 1) == 1;
            dmem_ready  = ($urandom_range(0, 3) != 0);
            halt_req    = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 3-stage RISC-V core (F, D, E).
- Drives the enable and flush inputs of the F/D and D/E pipeline registers.
- Sequences the data-memory request/ready handshake for E-stage accesses.
- Handles load-use bubbles, redirect squashes, halt requests and memory timeouts, and keeps a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before the block enters ERR.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- redirectE  in  1  branch taken or jump resolved in E.
- mem_accessE  in  1  E instruction accesses dmem.
- mem_writeE  in  1  E access is a store.
- reg_writeE  in  1  E instruction writes rd.
- rdE  in  5  E destination register.
- adr1D  in  5  D rs1 address.
- adr2D  in  5  D rs2 address.
- use_rs1D  in  1  D instruction reads rs1.
- use_rs2D  in  1  D instruction reads rs2.
- dmem_ready  in  1  dmem completes the access this cycle.
- halt_req  in  1  debug halt request (level).
- stallF  out  1  hold PC.
- stallD  out  1  hold F/D register.
- stallE  out  1  hold D/E register.
- flushD  out  1  zero F/D register.
- flushE  out  1  zero D/E register.
- dmem_req  out  1  memory request strobe.
- state  out  2  FSM state (RUN=0, MEM_WAIT=1, HALT=2, ERR=3).
- mem_timeout_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  saturating count of stallF cycles.

Behaviour:
- Clock and reset: all state updates on posedge clk. The block has one clock and a synchronous active-low reset, rst_n.
- Reset (rst_n=0 at an edge):
  - state=RUN, wait counter=0, mem_timeout_err=0, stall_cnt=0.
  - Reset wins over every other event, including mid-MEM_WAIT and ERR.
- Output values while rst_n=0 (combinational): stallF=stallD=stallE=0, flushD=flushE=1, dmem_req=0.
- Signal derivation: outputs are combinational from registered state and current inputs; zero added latency.
  - loadE = mem_accessE & ~mem_writeE & reg_writeE & (rdE!=0).
  - hazard = loadE & ((use_rs1D & adr1D==rdE) | (use_rs2D & adr2D==rdE)).
- RUN, evaluated in priority order:
  1. mem_accessE:
     - dmem_req=1.
     - If dmem_ready: access completes this cycle; continue to rules 2-4 for this cycle.
     - Else: stallF=stallD=stallE=1, no flushes, next state=MEM_WAIT, wait counter=1.
  2. redirectE: flushD=1, flushE=1, no stalls. This squashes the two wrong-path instructions. Redirect overrides hazard.
  3. hazard: stallF=stallD=1, flushE=1 (one bubble). Next cycle the load has left E, so the hazard clears.
  4. halt_req with no stall or flush this cycle: next state=HALT. A halt request is taken only on a clean cycle.
- MEM_WAIT:
  - dmem_req=1, stallF=stallD=stallE=1, flushes=0. The E inputs are held stable, so redirectE stays asserted.
  - On dmem_ready: stalls drop the same cycle, then rule 2/3 logic applies (a pending redirect flushes that cycle). Next state=RUN, counter cleared.
  - Else, when the counter reaches MEM_TIMEOUT: next state=ERR.
  - Else: counter increments.
  - halt_req is ignored in this state.
- HALT:
  - stallF=stallD=stallE=1, dmem_req=0, flushes=0.
  - When halt_req=0: next state=RUN.
- ERR:
  - stallF=stallD=stallE=1, dmem_req=0, mem_timeout_err=1.
  - Exits only via reset.
- stall_cnt:
  - Increments on every cycle with stallF=1, outside reset.
  - Saturates at 2^CNT_W-1; no wrap.

Test Plan:
- Load-use: lw x5 in E (loadE), D uses rs1=x5, dmem_ready=1 -> exactly one cycle of stallF=stallD=1, flushE=1; stall_cnt=1. Same sequence with rdE=0 -> no stall.
- Redirect plus hazard in the same cycle: redirectE=1, hazard=1 -> flushD=flushE=1, stallF=0, stall_cnt unchanged.
- Memory wait: store in E, dmem_ready low for 3 cycles -> state=1 for 3 cycles, stallE=1 and dmem_req=1 throughout, stall_cnt=3; ready cycle -> state=0 next, no flush.
- Wait then redirect: load in E plus redirectE, ready after 2 cycles -> stalls for 2 cycles, then flushD=flushE=1 on the ready cycle.
- Timeout: dmem_ready held 0 -> after 255 wait cycles state=3, mem_timeout_err=1, dmem_req=0. rst_n=0 at one edge -> state=0, err=0, stall_cnt=0.
- Halt and saturation: halt_req=1 on a clean cycle -> HALT next, all stalls=1; halt_req=0 -> RUN. With CNT_W=4, hold 20 stall cycles -> stall_cnt=15.
